// File: rtl/double_pkg.sv
// Shared IEEE-754 double helpers: field positions, canonical constants, NaN test,
// plus the checker's state and delay-line entry types.
package double_pkg;

  localparam int DOUBLE_W = 64;
  localparam int SIGN_BIT = 63;
  localparam int EXP_MSB  = 62;
  localparam int EXP_LSB  = 52;
  localparam int MAN_MSB  = 51;
  localparam int MAN_LSB  = 0;

  localparam logic [DOUBLE_W-1:0] CANON_QNAN = 64'h7FF8000000000000;
  localparam logic [DOUBLE_W-1:0] POS_ZERO   = 64'h0000000000000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

  typedef struct packed {
    logic                valid;
    logic [DOUBLE_W-1:0] value;
  } dly_entry_t;

  // Exponent all-ones with a nonzero mantissa; infinities are not NaN.
  function automatic logic is_nan(input logic [DOUBLE_W-1:0] x);
    return (&x[EXP_MSB:EXP_LSB]) && (|x[MAN_MSB:MAN_LSB]);
  endfunction

endpackage

// File: rtl/double_max_ref.sv
// Combinational golden maximum of two IEEE-754 doubles: NaN in -> canonical qNaN,
// +0 beats -0, otherwise sign-magnitude compare with ties resolved to a.
module double_max_ref
  import double_pkg::*;
(
  input  logic [DOUBLE_W-1:0] a,
  input  logic [DOUBLE_W-1:0] b,
  output logic [DOUBLE_W-1:0] z
);

  logic                a_sign;
  logic                b_sign;
  logic [DOUBLE_W-2:0] a_mag;
  logic [DOUBLE_W-2:0] b_mag;
  logic                a_wins;

  assign a_sign = a[SIGN_BIT];
  assign b_sign = b[SIGN_BIT];
  assign a_mag  = a[DOUBLE_W-2:0];
  assign b_mag  = b[DOUBLE_W-2:0];

  always_comb begin
    // NOTE: every output gets a default before any branch, so always_comb never infers a latch.
    a_wins = 1'b1;
    z      = a;
    if (a_sign != b_sign) begin
      a_wins = b_sign;
    end else if (a_sign) begin
      // Both negative: the smaller magnitude is the larger value.
      a_wins = (a_mag <= b_mag);
    end else begin
      a_wins = (a_mag >= b_mag);
    end
    z = a_wins ? a : b;
    if ((a_mag == '0) && (b_mag == '0) && (a_sign != b_sign)) begin
      z = POS_ZERO;
    end
    if (is_nan(a) || is_nan(b)) begin
      z = CANON_QNAN;
    end
  end

endmodule

// File: rtl/double_max_checker.sv
// Self-checking receiver for the double_max result stream: golden max delayed by
// LATENCY, compared against dut_z. Define DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN to end on first mismatch.
module double_max_checker
  import double_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                in_valid,
  input  logic [DOUBLE_W-1:0] a,
  input  logic [DOUBLE_W-1:0] b,
  input  logic [DOUBLE_W-1:0] dut_z,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         check_count,
  output logic [CNT_W-1:0]    error_count,
  output logic [31:0]         first_err_idx,
  output logic [DOUBLE_W-1:0] first_err_exp,
  output logic [DOUBLE_W-1:0] first_err_got
);

  localparam int                DCNT_W     = 4;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(LATENCY - 1);

  chk_state_t          state;
  chk_state_t          next_state;
  dly_entry_t          dly [LATENCY];
  logic [DCNT_W-1:0]   drain_cnt;
  logic [DOUBLE_W-1:0] golden;
  logic [DOUBLE_W-1:0] expected;
  logic                active;
  logic                enqueue;
  logic                compare;
  logic                matched;
  logic                mismatch;
  logic                err_sat;

  double_max_ref u_ref (
    .a (a),
    .b (b),
    .z (golden)
  );

  assign active   = (state == ST_CHECK) || (state == ST_DRAIN);
  assign enqueue  = in_valid && (state == ST_CHECK);
  assign expected = dly[LATENCY-1].value;
  assign compare  = dly[LATENCY-1].valid && active && !start;
  assign matched  = (expected == dut_z) || (is_nan(expected) && is_nan(dut_z));
  assign mismatch = compare && !matched;
  assign err_sat  = &error_count;

  // NOTE: the delay line is reset like any other register; a stale valid bit would be compared after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
      dly[0] <= '{valid: enqueue, value: golden};
      for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_count   <= '0;
      error_count   <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start) begin
      check_count   <= '0;
      error_count   <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (compare) begin
      check_count <= check_count + 32'd1;
      if (mismatch) begin
        if (!err_sat) error_count <= error_count + CNT_W'(1);
        if (error_count == '0) begin
          first_err_idx <= check_count;
          first_err_exp <= expected;
          first_err_got <= dut_z;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DCNT_W'(1) : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  next_state = ST_IDLE;
      ST_CHECK: if (stop) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = ST_DONE;
      ST_DONE:  next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
`ifdef DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN
    if (mismatch) next_state = ST_DONE;
`endif
    // start overrides everything, including a simultaneous stop.
    if (start) next_state = ST_CHECK;
  end

  assign busy = active;
  assign done = (state == ST_DONE);
  assign pass = done && (error_count == '0) && (check_count != 32'd0);

endmodule

// File: tb/tb_double_max_checker.sv
// Bench for double_max_checker: LATENCY=1 (CNT_W=3) and LATENCY=3 instances share stimulus;
// a real-arithmetic reference model scores every session.
module tb_double_max_checker;

  localparam logic [63:0] ONE      = 64'h3FF0000000000000;
  localparam logic [63:0] TWO      = 64'h4000000000000000;
  localparam logic [63:0] NEG_ZERO = 64'h8000000000000000;
  localparam logic [63:0] QNAN     = 64'h7FF8000000000000;

  logic        clk = 1'b0;
  logic        rst, start, stop, in_valid;
  logic [63:0] a, b, resp_z;
  logic [63:0] fz [3];

  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [31:0] cc1, fidx1, cc3, fidx3;
  logic [2:0]  ec1;
  logic [15:0] ec3;
  logic [63:0] fexp1, fgot1, fexp3, fgot3;

  int checks = 0;
  int errors = 0;

  int          m_checks, m_errs;
  logic [31:0] m_fidx;
  logic [63:0] m_fexp, m_fgot;
  bit          m_active;

  always #5 clk = ~clk;

  // Stand-in for double_max: returns resp_z one and three clocks after it was presented.
  always @(posedge clk) begin
    fz[0] <= resp_z;
    fz[1] <= fz[0];
    fz[2] <= fz[1];
  end

  double_max_checker #(.LATENCY(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .dut_z(fz[0]), .busy(busy1), .done(done1), .pass(pass1),
    .check_count(cc1), .error_count(ec1), .first_err_idx(fidx1),
    .first_err_exp(fexp1), .first_err_got(fgot1)
  );

  double_max_checker #(.LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .dut_z(fz[2]), .busy(busy3), .done(done3), .pass(pass3),
    .check_count(cc3), .error_count(ec3), .first_err_idx(fidx3),
    .first_err_exp(fexp3), .first_err_got(fgot3)
  );

  function automatic logic tb_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'h0);
  endfunction

  function automatic logic [63:0] golden(input logic [63:0] x, input logic [63:0] y);
    real rx, ry;
    if (tb_nan(x) || tb_nan(y)) return QNAN;
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    if (rx > ry) return x;
    if (ry > rx) return y;
    if (x != y) return 64'h0;  // only +0 / -0 are numerically equal with different bits
    return x;
  endfunction

  function automatic logic [63:0] rand_nan();
    logic [63:0] r;
    r        = {$urandom, $urandom};
    r[62:52] = 11'h7FF;
    r[32]    = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] rand_double();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: r = 64'h0;
      1: r = NEG_ZERO;
      2: r = 64'h7FF0000000000000;
      3: r = 64'hFFF0000000000000;
      4: r = rand_nan();
      5: r[62:52] = 11'h0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    m_checks = 0;
    m_errs   = 0;
    m_fidx   = '0;
    m_fexp   = '0;
    m_fgot   = '0;
  endtask

  task automatic model_sample(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] xz);
    logic [63:0] g;
    g = golden(xa, xb);
    if (!((xz === g) || (tb_nan(xz) && tb_nan(g)))) begin
      if (m_errs == 0) begin
        m_fidx = 32'(m_checks);
        m_fexp = g;
        m_fgot = xz;
      end
      m_errs++;
    end
    m_checks++;
  endtask

  task automatic send(input logic v, input logic [63:0] xa, input logic [63:0] xb,
                      input logic [63:0] xz, input logic sp);
    if (v && m_active) model_sample(xa, xb, xz);
    start = 1'b0; stop = sp; in_valid = v; a = xa; b = xb; resp_z = xz;
    @(negedge clk);
    stop = 1'b0; in_valid = 1'b0;
    if (sp) m_active = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1; stop = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    m_active = 1'b1;
  endtask

  task automatic verify_results(input string name);
    int          exp_ec, obs_ec, lat;
    logic        obs_done, obs_pass, exp_pass;
    logic [31:0] obs_cc, obs_fidx;
    logic [63:0] obs_fexp, obs_fgot;
    exp_pass = (m_errs == 0) && (m_checks > 0);
    for (int i = 0; i < 2; i++) begin
      lat      = (i == 0) ? 1 : 3;
      exp_ec   = (i == 0 && m_errs > 7) ? 7 : m_errs;
      obs_ec   = (i == 0) ? int'(ec1) : int'(ec3);
      obs_done = (i == 0) ? done1 : done3;
      obs_pass = (i == 0) ? pass1 : pass3;
      obs_cc   = (i == 0) ? cc1 : cc3;
      obs_fidx = (i == 0) ? fidx1 : fidx3;
      obs_fexp = (i == 0) ? fexp1 : fexp3;
      obs_fgot = (i == 0) ? fgot1 : fgot3;
      checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL %s lat%0d done: got %0b want 1", name, lat, obs_done); end
      checks++; if (obs_pass !== exp_pass) begin errors++; $display("FAIL %s lat%0d pass: got %0b want %0b", name, lat, obs_pass, exp_pass); end
      checks++; if (obs_cc !== 32'(m_checks)) begin errors++; $display("FAIL %s lat%0d check_count: got %0d want %0d", name, lat, obs_cc, m_checks); end
      checks++; if (obs_ec !== exp_ec) begin errors++; $display("FAIL %s lat%0d error_count: got %0d want %0d", name, lat, obs_ec, exp_ec); end
      checks++; if (obs_fidx !== m_fidx) begin errors++; $display("FAIL %s lat%0d first_err_idx: got %0d want %0d", name, lat, obs_fidx, m_fidx); end
      checks++; if (obs_fexp !== m_fexp) begin errors++; $display("FAIL %s lat%0d first_err_exp: got %h want %h", name, lat, obs_fexp, m_fexp); end
      checks++; if (obs_fgot !== m_fgot) begin errors++; $display("FAIL %s lat%0d first_err_got: got %h want %h", name, lat, obs_fgot, m_fgot); end
    end
  endtask

  // Called right after the stop cycle; optionally keeps offering samples, which must be ignored.
  task automatic finish_session(input string name, input bit junk);
    int d1, d3;
    d1 = 0; d3 = 0;
    checks++;
    if (!(busy1 && busy3 && !done1 && !done3)) begin
      errors++; $display("FAIL %s drain_entry: busy=%0b%0b done=%0b%0b want busy=11 done=00", name, busy1, busy3, done1, done3);
    end
    for (int n = 1; n <= 12; n++) begin
      if (junk) begin
        in_valid = 1'b1; a = rand_double(); b = rand_double(); resp_z = ~golden(a, b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (done1 && d1 == 0) d1 = n;
      if (done3 && d3 == 0) d3 = n;
    end
    checks++; if (d1 !== 1) begin errors++; $display("FAIL %s drain_len_lat1: got %0d want 1", name, d1); end
    checks++; if (d3 !== 3) begin errors++; $display("FAIL %s drain_len_lat3: got %0d want 3", name, d3); end
    verify_results(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; a = '0; b = '0; resp_z = '0;
    m_active = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, cc1, ec1, fidx1, fexp1, fgot1} !== '0) begin
      errors++; $display("FAIL reset lat1 outputs: got busy=%0b done=%0b cc=%0d ec=%0d fexp=%h", busy1, done1, cc1, ec1, fexp1);
    end
    checks++;
    if ({busy3, done3, pass3, cc3, ec3, fidx3, fexp3, fgot3} !== '0) begin
      errors++; $display("FAIL reset lat3 outputs: got busy=%0b done=%0b cc=%0d ec=%0d fexp=%h", busy3, done3, cc3, ec3, fexp3);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, ONE, TWO, ONE, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, cc1, busy3, done3, cc3} !== '0) begin
      errors++; $display("FAIL idle_ignores_input: busy=%0b%0b done=%0b%0b cc=%0d/%0d want all 0", busy1, busy3, done1, done3, cc1, cc3);
    end
  endtask

  task automatic test_basic();
    begin_session();
    checks++;
    if (!(busy1 && busy3) || done1 || done3) begin
      errors++; $display("FAIL basic start_busy: busy=%0b%0b done=%0b%0b want busy=11 done=00", busy1, busy3, done1, done3);
    end
    send(1'b1, ONE, TWO, TWO, 1'b1);
    finish_session("basic", 1'b0);
    checks++; if (cc3 !== 32'd1 || pass3 !== 1'b1) begin errors++; $display("FAIL basic plan: cc=%0d pass=%0b want 1 1", cc3, pass3); end
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 3; i++) send(1'b1, ONE, TWO, ONE, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (busy1 || busy3) begin errors++; $display("FAIL ignored busy: got %0b%0b want 00", busy1, busy3); end
    verify_results("ignored_in_done");
  endtask

  task automatic test_zero_sign();
    begin_session();
    send(1'b1, NEG_ZERO, 64'h0, NEG_ZERO, 1'b1);
    finish_session("zero_sign", 1'b0);
    checks++;
    if (ec3 !== 16'd1 || fexp3 !== 64'h0 || fgot3 !== NEG_ZERO || fidx3 !== 32'd0) begin
      errors++; $display("FAIL zero_sign plan: ec=%0d exp=%h got=%h idx=%0d", ec3, fexp3, fgot3, fidx3);
    end
  endtask

  task automatic test_nan_match();
    begin_session();
    send(1'b1, 64'h7FF0000000000001, ONE, 64'h7FF8000000000001, 1'b1);
    finish_session("nan_match", 1'b0);
    checks++; if (ec3 !== 16'd0 || pass3 !== 1'b1) begin errors++; $display("FAIL nan_match plan: ec=%0d pass=%0b want 0 1", ec3, pass3); end
  endtask

  task automatic test_random();
    logic [63:0] xa, xb, xz;
    begin_session();
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) send(1'b0, rand_double(), rand_double(), rand_double(), 1'b0);
      xa = rand_double();
      case ($urandom_range(0, 7))
        0:       xb = xa;
        1:       xb = xa ^ NEG_ZERO;
        default: xb = rand_double();
      endcase
      xz = golden(xa, xb);
      if (tb_nan(xz) && $urandom_range(0, 1) == 1) xz = rand_nan();
      send(1'b1, xa, xb, xz, i == 99);
    end
    finish_session("random", 1'b1);
    checks++; if (cc3 !== 32'd100 || pass3 !== 1'b1) begin errors++; $display("FAIL random plan: cc=%0d pass=%0b want 100 1", cc3, pass3); end
  endtask

  task automatic test_errors();
    logic [63:0] xa, xb, xz;
    begin_session();
    for (int i = 0; i < 40; i++) begin
      xa = rand_double();
      xb = rand_double();
      xz = golden(xa, xb);
      if ($urandom_range(0, 9) < 4) xz = xz ^ (64'h1 << $urandom_range(0, 63));
      send(1'b1, xa, xb, xz, i == 39);
    end
    finish_session("errors", 1'b0);
  endtask

  task automatic test_saturation();
    begin_session();
    for (int i = 0; i < 10; i++) send(1'b1, ONE, TWO, ONE, i == 9);
    finish_session("saturation", 1'b0);
    checks++; if (ec1 !== 3'd7 || ec3 !== 16'd10) begin errors++; $display("FAIL saturation counts: got %0d/%0d want 7/10", ec1, ec3); end
  endtask

  task automatic test_start_stop_same();
    begin_session();
    for (int i = 0; i < 3; i++) send(1'b1, ONE, TWO, TWO, 1'b0);
    start = 1'b1; stop = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    model_clear();
    m_active = 1'b1;
    checks++;
    if (!(busy1 && busy3) || done1 || done3 || cc1 !== 32'd0 || cc3 !== 32'd0) begin
      errors++; $display("FAIL start_stop clear: busy=%0b%0b done=%0b%0b cc=%0d/%0d want busy=11 done=00 cc=0", busy1, busy3, done1, done3, cc1, cc3);
    end
    for (int i = 0; i < 4; i++) send(1'b1, TWO, ONE, TWO, i == 3);
    finish_session("start_stop", 1'b0);
  endtask

  task automatic test_rst_mid_drain();
    begin_session();
    send(1'b1, ONE, TWO, TWO, 1'b0);
    send(1'b1, ONE, TWO, ONE, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, pass1, cc1, ec1, fidx1, fexp1, fgot1, busy3, done3, pass3, cc3, ec3, fidx3, fexp3, fgot3} !== '0) begin
      errors++; $display("FAIL rst_mid_drain outputs: busy=%0b%0b cc=%0d/%0d ec=%0d/%0d want all 0", busy1, busy3, cc1, cc3, ec1, ec3);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy1, done1, cc1, ec1, busy3, done3, cc3, ec3} !== '0) begin
      errors++; $display("FAIL rst_mid_drain idle: busy=%0b%0b done=%0b%0b cc=%0d/%0d want all 0", busy1, busy3, done1, done3, cc1, cc3);
    end
  endtask

  task automatic test_stop_on_err();
    logic [63:0] xa, xz;
    begin_session();
    for (int i = 0; i < 10; i++) begin
      xa = $realtobits(real'(i));
      xz = golden(xa, TWO);
      if (i == 5) xz = xz ^ 64'h1;
      send(1'b1, xa, TWO, xz, 1'b0);
      if (i == 5) begin
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL stop_on_err early_done: got %0b want 0", done1); end
      end
      if (i == 6) begin
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL stop_on_err done_next: got %0b want 1", done1); end
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (cc1 !== 32'd6 || cc3 !== 32'd6) begin errors++; $display("FAIL stop_on_err check_count: got %0d/%0d want 6/6", cc1, cc3); end
    checks++; if (pass1 || pass3 || !done1 || !done3) begin errors++; $display("FAIL stop_on_err status: pass=%0b%0b done=%0b%0b want pass=00 done=11", pass1, pass3, done1, done3); end
    checks++; if (ec3 !== 16'd1 || fidx3 !== 32'd5) begin errors++; $display("FAIL stop_on_err first_err: ec=%0d idx=%0d want 1 5", ec3, fidx3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored();
`ifndef DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN
    test_zero_sign();
`endif
    test_nan_match();
    test_random();
`ifndef DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN
    test_errors();
    test_saturation();
`endif
    test_start_stop_same();
    test_rst_mid_drain();
`ifdef DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN
    test_stop_on_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/double_max_checker.md
Name: double_max_checker

Overview:
- Synthesizable self-checking receiver for the double_max result stream.
- Consumes the same operand pairs (a, b) driven into double_max, plus the DUT's z output.
- Computes the golden maximum internally and delays it by the DUT's pipeline latency.
- Compares against z and reports pass/fail, check and mismatch counts, and the first failing sample. Sits beside double_max in regression benches and FPGA self-test builds.

Parameters:
- LATENCY, 1: DUT clocks from operands sampled to z valid; legal range 1..8.
- CNT_W, 16: width of error_count; saturates at all-ones.

Ports:
- clk  in  1: single clock, all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: pulse; clears counters, enters CHECK.
- stop  in  1: pulse; ends stimulus, drains in-flight samples.
- in_valid  in  1: a/b this cycle are a real sample (same cycle they reach double_max).
- a  in  64: operand A, IEEE-754 double.
- b  in  64: operand B, IEEE-754 double.
- dut_z  in  64: double_max output.
- busy  out  1: high in CHECK or DRAIN.
- done  out  1: high in DONE, held until start or rst.
- pass  out  1: valid when done; 1 iff error_count==0 and check_count>0.
- check_count  out  32: samples compared.
- error_count  out  CNT_W: mismatches, saturating.
- first_err_idx  out  32: check_count value at first mismatch.
- first_err_exp  out  64: golden value at first mismatch.
- first_err_got  out  64: dut_z at first mismatch.

Behaviour:
- Reset: state IDLE; busy=0, done=0, pass=0; all counters, first_err_* and the delay line = 0.
- Golden rule, combinational on a/b:
  - either operand NaN -> 64'h7FF8000000000000;
  - +0 vs -0 -> +0 (64'h0);
  - otherwise the numerically larger value by sign-magnitude compare;
  - equal operands -> a.
- Delay line: LATENCY-deep shift register of {valid, expected}. Shifts every cycle. Entry valid = in_valid and state==CHECK.
- Compare fires when the delay-line output valid=1 and state is CHECK or DRAIN.
  - Match: bit-exact equality, or both values NaN (exponent all-ones, mantissa nonzero).
  - Every compare: check_count+1.
  - Mismatch: error_count+1, saturating. first_err_* captured only when error_count was 0 before this compare.
- FSM:
  - IDLE -start-> CHECK.
  - CHECK -stop-> DRAIN.
  - DRAIN: counts LATENCY cycles, then DONE.
  - DONE -start-> CHECK.
- start in any state clears counters, first_err_* and the delay line the same cycle, then enters CHECK. start wins over simultaneous stop.
- stop outside CHECK is ignored.
- in_valid in DRAIN, IDLE or DONE is ignored (not enqueued).
- Counter overflow: check_count wraps at 2^32. error_count sticks at all-ones.
- rst mid-operation: immediate return to reset values; in-flight samples discarded.

Optional Feature:
- Macro: DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN.
- Defined: the first mismatch moves CHECK or DRAIN directly to DONE the next cycle. Remaining in-flight samples are not compared; pass=0.
- Undefined: all samples are compared to the end of DRAIN.

Decomposition:
- Shared package double_pkg: DOUBLE_W=64, CANON_QNAN=64'h7FF8000000000000, POS_ZERO, exponent/mantissa field ranges, is_nan function.
- Sub-module double_max_ref: combinational golden max, reused by other checkers.
- The FSM, delay line and counters stay in double_max_checker.

Test Plan:
- Reset, start; a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), DUT model z=0x4000000000000000 after 1 cycle; stop -> done=1, pass=1, check_count=1, error_count=0.
- a=0x8000000000000000 (-0), b=0x0 (+0), DUT returns 0x8000000000000000 -> error_count=1, first_err_exp=0x0, first_err_got=0x8000000000000000, first_err_idx=0.
- a=0x7FF0000000000001 (NaN), b=1.0, DUT returns 0x7FF8000000000001 -> NaN-vs-NaN match, error_count=0.
- LATENCY=3: 100 random samples with a correct DUT model, stop on last sample -> DRAIN lasts 3 cycles, check_count=100, pass=1.
- start and stop asserted in the same cycle while in CHECK -> counters cleared, state stays CHECK; rst mid-DRAIN -> all outputs 0 the next cycle.
- With DOUBLE_MAX_CHECKER_STOP_ON_ERR_EN: mismatch on sample 5 of 10 -> done=1 the following cycle, check_count=6, pass=0.
